sevenseg_scan_reader: RTL and testbench

- Reads a multiplexed, active-low seven-segment display bus: segment lines plus per-digit anode enables.
- Recovers the hex nibble shown on each digit and assembles one word per full scan frame.
- Presents each frame on a valid/ready handshake.
- Sits at the receive end of a display link. Used for loop-back checking of the display path and for capturing readouts from external scanned displays.

---
 rtl/sevenseg_pkg.sv | 44 ++++
 rtl/sevenseg_stable_sampler.sv | 72 +++++++
 rtl/sevenseg_scan_reader.sv | 117 +++++++++++
 tb/tb_sevenseg_scan_reader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared seven-segment definitions: glyph table (a = MSB, active-low), reverse decode,
// and the scan-reader FSM state type.
package sevenseg_pkg;

    localparam int unsigned SEG_A_BIT = 6;
    localparam int unsigned SEG_G_BIT = 0;

    typedef logic [SEG_A_BIT:SEG_G_BIT] seg_t;

    localparam seg_t GLYPH_0 = 7'b0000001;
    localparam seg_t GLYPH_1 = 7'b1001111;
    localparam seg_t GLYPH_2 = 7'b0010010;
    localparam seg_t GLYPH_3 = 7'b0000110;
    localparam seg_t GLYPH_4 = 7'b1001100;
    localparam seg_t GLYPH_5 = 7'b0100100;
    localparam seg_t GLYPH_6 = 7'b0100000;
    localparam seg_t GLYPH_7 = 7'b0001101;
    localparam seg_t GLYPH_8 = 7'b0000000;
    localparam seg_t GLYPH_9 = 7'b0000100;
    localparam seg_t GLYPH_A = 7'b0001000;
    localparam seg_t GLYPH_B = 7'b1100000;
    localparam seg_t GLYPH_C = 7'b0110001;
    localparam seg_t GLYPH_D = 7'b1000010;
    localparam seg_t GLYPH_E = 7'b0110000;
    localparam seg_t GLYPH_F = 7'b0111000;

    localparam seg_t [15:0] GLYPHS = {
        GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
        GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
    };

    typedef enum logic [1:0] {StIdle, StTrack, StHold} scan_state_e;

    // Returns {err, nibble}; unknown patterns decode to nibble 0 with err set.
    function automatic logic [4:0] seg_to_nibble(input seg_t segs);
        logic [4:0] res;
        res = 5'b1_0000;
        for (int i = 0; i < 16; i++) begin
            if (segs == GLYPHS[i]) res = {1'b0, 4'(i)};
        end
        return res;
    endfunction

endpackage

// File: rtl/sevenseg_stable_sampler.sv
// Synchronises the segment/anode bus, detects changes, counts stability and flags a
// one-cycle accept when a valid (single-anode) sample has been stable long enough.
module sevenseg_stable_sampler import sevenseg_pkg::*; #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned STABLE_CNT  = 4,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  seg_t                  segs_i,
    input  logic [NUM_DIGITS-1:0] an_i,
    output logic                  valid_o,
    output logic                  changed_o,
    output logic                  accept_o,
    output logic [IdxW-1:0]       idx_o,
    output seg_t                  segs_o
);

    seg_t [SYNC_STAGES-1:0]                  segs_sync_q;
    logic [SYNC_STAGES-1:0][NUM_DIGITS-1:0] an_sync_q;
    seg_t                                    segs_prev_q;
    logic [NUM_DIGITS-1:0]                   an_prev_q;
    logic [7:0]                              cnt_q, cnt_d;
    seg_t                                    s_segs;
    logic [NUM_DIGITS-1:0]                   s_an, an_low;

    assign s_segs = segs_sync_q[SYNC_STAGES-1];
    assign s_an   = an_sync_q[SYNC_STAGES-1];
    assign an_low = ~s_an;

    // Exactly one anode low: nonzero and a power of two.
    assign valid_o   = (an_low != '0) && ((an_low & (an_low - 1'b1)) == '0);
    assign changed_o = (s_segs != segs_prev_q) || (s_an != an_prev_q);
    assign segs_o    = s_segs;

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!s_an[i]) idx_o = IdxW'(i);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (changed_o) begin
            cnt_d = '0;
        end else if (cnt_q < 8'(STABLE_CNT)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Fires on the cycle the counter reaches STABLE_CNT; saturation keeps it one-shot.
    assign accept_o = valid_o && !changed_o && (cnt_q == 8'(STABLE_CNT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segs_sync_q <= '0;
            an_sync_q   <= '0;
            segs_prev_q <= '0;
            an_prev_q   <= '0;
            cnt_q       <= '0;
        end else begin
            segs_sync_q <= {segs_sync_q[SYNC_STAGES-2:0], segs_i};
            an_sync_q   <= {an_sync_q[SYNC_STAGES-2:0], an_i};
            segs_prev_q <= s_segs;
            an_prev_q   <= s_an;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: rtl/sevenseg_scan_reader.sv
// Receive side of a scanned seven-segment link: captures each digit into a slot and
// publishes a full frame over valid/ready, flagging dropped frames as overrun.
module sevenseg_scan_reader import sevenseg_pkg::*; #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned STABLE_CNT  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              segs_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    input  logic                    frame_ready,
    output logic                    frame_valid,
    output logic [4*NUM_DIGITS-1:0] frame_data,
    output logic [NUM_DIGITS-1:0]   frame_err,
    output logic                    overrun
);

    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic            smp_valid, smp_changed, smp_accept;
    logic [IdxW-1:0] smp_idx;
    seg_t            smp_segs;
    logic [4:0]      dec;
    logic            wr, frame_done;

    scan_state_e                 state_q;
    logic [NUM_DIGITS-1:0][3:0]  slot_nib_q, slot_nib_d;
    logic [NUM_DIGITS-1:0]       slot_err_q, slot_err_d;
    logic [NUM_DIGITS-1:0]       mask_q, mask_d;
    logic                        frame_valid_q, overrun_q;
    logic [NUM_DIGITS-1:0][3:0]  frame_data_q;
    logic [NUM_DIGITS-1:0]       frame_err_q;

    sevenseg_stable_sampler #(
        .NUM_DIGITS (NUM_DIGITS),
        .STABLE_CNT (STABLE_CNT),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sampler (
        .clk      (clk),
        .rst_n    (rst_n),
        .segs_i   (segs_in),
        .an_i     (an_in),
        .valid_o  (smp_valid),
        .changed_o(smp_changed),
        .accept_o (smp_accept),
        .idx_o    (smp_idx),
        .segs_o   (smp_segs)
    );

    assign dec        = seg_to_nibble(smp_segs);
    assign wr         = smp_accept && (state_q == StTrack);
    assign frame_done = &mask_q;

    // Slot write lands before frame load; a completing write is seen next cycle via mask_q.
    always_comb begin
        slot_nib_d = slot_nib_q;
        slot_err_d = slot_err_q;
        mask_d     = mask_q;
        if (wr) begin
            slot_nib_d[smp_idx] = dec[3:0];
            slot_err_d[smp_idx] = dec[4];
            mask_d[smp_idx]     = 1'b1;
        end
        if (frame_done) mask_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            slot_nib_q    <= '0;
            slot_err_q    <= '0;
            mask_q        <= '0;
            frame_valid_q <= 1'b0;
            frame_data_q  <= '0;
            frame_err_q   <= '0;
            overrun_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle:  if (smp_valid) state_q <= StTrack;
                StTrack: begin
                    if (!smp_valid)      state_q <= StIdle;
                    else if (smp_accept) state_q <= StHold;
                end
                StHold: begin
                    if (!smp_valid)       state_q <= StIdle;
                    else if (smp_changed) state_q <= StTrack;
                end
                default: state_q <= StIdle;
            endcase

            slot_nib_q <= slot_nib_d;
            slot_err_q <= slot_err_d;
            mask_q     <= mask_d;

            if (frame_valid_q && frame_ready) begin
                frame_valid_q <= 1'b0;
                overrun_q     <= 1'b0;
            end
            if (frame_done) begin
                if (!frame_valid_q || frame_ready) begin
                    frame_valid_q <= 1'b1;
                    frame_data_q  <= slot_nib_d;
                    frame_err_q   <= slot_err_d;
                end else begin
                    overrun_q <= 1'b1;
                end
            end
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame_data  = frame_data_q;
    assign frame_err   = frame_err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_sevenseg_scan_reader.sv
// Scoreboard bench for sevenseg_scan_reader: expected frames are queued as scans are
// driven and compared whenever the reader hands a frame over.
module tb_sevenseg_scan_reader;
    import sevenseg_pkg::*;

    localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010;
    localparam logic [6:0] G3 = 7'b0000110, G4 = 7'b1001100, G5 = 7'b0100100;
    localparam logic [6:0] G6 = 7'b0100000, G7 = 7'b0001101, G8 = 7'b0000000;
    localparam logic [6:0] G9 = 7'b0000100, GA = 7'b0001000, GB = 7'b1100000;
    localparam logic [6:0] GC = 7'b0110001, GD = 7'b1000010, GE = 7'b0110000;
    localparam logic [6:0] GF = 7'b0111000, BLANK = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  segs_in = BLANK;
    logic [3:0]  an_in = 4'b1111;
    logic        frame_ready = 1'b0;
    logic        frame_valid;
    logic [15:0] frame_data;
    logic [3:0]  frame_err;
    logic        overrun;

    int n_checks = 0;
    int n_errors = 0;
    logic [19:0] exp_q[$];   // {err, data}
    logic        left_idle;

    sevenseg_scan_reader #(
        .NUM_DIGITS (4),
        .STABLE_CNT (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .segs_in    (segs_in),
        .an_in      (an_in),
        .frame_ready(frame_ready),
        .frame_valid(frame_valid),
        .frame_data (frame_data),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Caller is always at posedge+1.
    task automatic show(input logic [3:0] an, input logic [6:0] segs, input int cycles);
        an_in   = an;
        segs_in = segs;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
        show(4'b1110, s0, 20);
        show(4'b1101, s1, 20);
        show(4'b1011, s2, 20);
        show(4'b0111, s3, 20);
        show(4'b1111, BLANK, 5);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && frame_valid && frame_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_frame", {12'd0, frame_err, frame_data}, 32'hFFFF_FFFF);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                check("frame_data", 32'(frame_data), 32'(e[15:0]));
                check("frame_err", 32'(frame_err), 32'(e[19:16]));
            end
        end
    end

    initial begin
        #3;
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_data", 32'(frame_data), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Clean scan.
        frame_ready = 1'b1;
        exp_q.push_back({4'b0000, 16'hFA03});
        scan4(G3, G0, GA, GF);
        drain("clean_drain");

        // Digit 0 too short, then completed later.
        show(4'b1110, G5, 3);
        show(4'b1101, G1, 20);
        show(4'b1011, G2, 20);
        show(4'b0111, G4, 20);
        show(4'b1111, BLANK, 5);
        check("short_no_frame", 32'(frame_valid), 32'd0);
        check("short_mask", 32'(dut.mask_q), 32'b1110);
        exp_q.push_back({4'b0000, 16'h4217});
        show(4'b1110, G7, 20);
        show(4'b1111, BLANK, 5);
        drain("short_drain");

        // Illegal glyph on digit 2.
        exp_q.push_back({4'b0100, 16'hE021});
        scan4(G1, G2, BLANK, GE);
        drain("blank_drain");

        // Ghost / blank anode patterns never capture.
        left_idle = 1'b0;
        an_in = 4'b1100;
        segs_in = G8;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (dut.state_q != StIdle) left_idle = 1'b1;
        end
        check("ghost_idle", 32'(left_idle), 32'd0);
        check("ghost_mask", 32'(dut.mask_q), 32'd0);
        an_in = 4'b1111;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (dut.state_q != StIdle) left_idle = 1'b1;
        end
        check("blank_idle", 32'(left_idle), 32'd0);
        check("blank_mask", 32'(dut.mask_q), 32'd0);
        @(posedge clk);
        #1;

        // Back-pressure: hold first frame, drop second.
        frame_ready = 1'b0;
        scan4(G8, G9, GB, GC);
        check("bp_valid1", 32'(frame_valid), 32'd1);
        check("bp_data1", 32'(frame_data), 32'hCB98);
        check("bp_overrun1", 32'(overrun), 32'd0);
        scan4(GD, G6, G4, G7);
        check("bp_valid2", 32'(frame_valid), 32'd1);
        check("bp_held", 32'(frame_data), 32'hCB98);
        check("bp_overrun2", 32'(overrun), 32'd1);
        exp_q.push_back({4'b0000, 16'hCB98});
        frame_ready = 1'b1;
        @(posedge clk);
        #1;
        frame_ready = 1'b0;
        @(negedge clk);
        check("bp_valid_fall", 32'(frame_valid), 32'd0);
        check("bp_overrun_clr", 32'(overrun), 32'd0);
        check("bp_popped", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;

        // Reset mid-frame with a pending frame.
        scan4(G5, BLANK, G6, G9);
        check("rs_valid", 32'(frame_valid), 32'd1);
        check("rs_data", 32'(frame_data), 32'h9605);
        check("rs_err", 32'(frame_err), 32'b0010);
        show(4'b1110, G2, 20);
        show(4'b1101, G3, 20);
        show(4'b1011, G4, 20);
        show(4'b1111, BLANK, 2);
        check("rs_mask", 32'(dut.mask_q), 32'b0111);
        rst_n = 1'b0;
        #2;
        check("rs_now_valid", 32'(frame_valid), 32'd0);
        check("rs_now_data", 32'(frame_data), 32'd0);
        check("rs_now_err", 32'(frame_err), 32'd0);
        check("rs_now_mask", 32'(dut.mask_q), 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        frame_ready = 1'b1;
        exp_q.push_back({4'b0000, 16'h1C0E});
        show(4'b0111, G1, 20);
        show(4'b1011, GC, 20);
        show(4'b1101, G0, 20);
        show(4'b1110, GE, 20);
        show(4'b1111, BLANK, 5);
        drain("rs_drain");

        repeat (10) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
